// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU-wide types. Only the RAM handshake state is needed by the arbiter.
//   ramstate_t : FREE (idle), BUSY (access in progress), ACCESS (word done),
//                ERROR (access failed).
// -----------------------------------------------------------------------------
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage : cpu_types_pkg

// File: rtl/ram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// ram_arbiter_pkg
// Types and constants shared by the RAM arbiter files.
//   arb_state_t : IDLE (no owner), WORD0 (first word), WORD1 (burst 2nd word)
//   WORD_BYTES  : byte stride between the two words of a burst
// ramstate_t comes from cpu_types_pkg and is imported alongside this package.
// -----------------------------------------------------------------------------
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WORD0 = 2'd1,
    WORD1 = 2'd2
  } arb_state_t;

  localparam int unsigned WORD_BYTES = 4;

endpackage : ram_arbiter_pkg

// File: rtl/ram_arbiter_if.sv
// -----------------------------------------------------------------------------
// ram_arbiter_if
// Bundles the per-requester bus and the single RAM port around the arbiter.
//   Requester side : req_ren/req_wen/req_burst/req_addr/req_store in,
//                    req_wait/req_word/req_load/req_err/grant out
//   RAM side       : ramREN/ramWEN/ramaddr/ramstore out, ramload/ramstate in
// Modports:
//   slave  : the arbiter itself
//   master : the environment (requesters plus RAM model)
// -----------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int NREQ   = 4,
  parameter int WORD_W = 32
);
  import cpu_types_pkg::*;

  logic [NREQ-1:0]             req_ren;
  logic [NREQ-1:0]             req_wen;
  logic [NREQ-1:0]             req_burst;
  logic [NREQ-1:0][WORD_W-1:0] req_addr;
  logic [NREQ-1:0][WORD_W-1:0] req_store;
  logic [NREQ-1:0]             req_wait;
  logic                        req_word;
  logic [WORD_W-1:0]           req_load;
  logic [NREQ-1:0]             req_err;
  logic [NREQ-1:0]             grant;

  logic                        ramREN;
  logic                        ramWEN;
  logic [WORD_W-1:0]           ramaddr;
  logic [WORD_W-1:0]           ramstore;
  logic [WORD_W-1:0]           ramload;
  ramstate_t                   ramstate;

  modport slave (
    input  req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
    output req_wait, req_word, req_load, req_err, grant,
           ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output req_ren, req_wen, req_burst, req_addr, req_store, ramload, ramstate,
    input  req_wait, req_word, req_load, req_err, grant,
           ramREN, ramWEN, ramaddr, ramstore
  );

endinterface : ram_arbiter_if

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Searches req_i starting at index ptr_i,
// then ptr_i+1, ... modulo NREQ, and returns the first hit one-hot.
//   req_i   : request vector
//   ptr_i   : search start index (0..NREQ-1)
//   gnt_o   : one-hot winner, 0 when nothing is requesting
//   valid_o : any request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic             valid_o
);

  logic [NREQ-1:0] rot;
  logic [NREQ-1:0] pick;

  // Rotate right so the pointer lands on bit 0; works for any NREQ because
  // ptr_i < NREQ and the doubled vector supplies the wrapped bits.
  assign rot  = NREQ'({req_i, req_i} >> ptr_i);
  // Isolate the lowest set bit: first requester at or after the pointer.
  assign pick = rot & (~rot + {{(NREQ-1){1'b0}}, 1'b1});
  // Rotate the one-hot pick back into requester numbering.
  assign gnt_o   = NREQ'(({pick, pick} << ptr_i) >> NREQ);
  assign valid_o = |req_i;

endmodule : rr_pick

// File: rtl/ram_arbiter.sv
// -----------------------------------------------------------------------------
// ram_arbiter
// Round-robin arbiter sharing one RAM port among NREQ requesters. Each
// requester issues a single-word or two-word (addr, addr+4) read or write;
// the granted requester's words are sequenced through the ramstate handshake.
//   CLK, nRST : clock (rising edge), asynchronous active-low reset
//   bus       : ram_arbiter_if.slave -- requester bus and RAM port
// Configuration macro:
//   RAM_ARB_WRITE_PRIO_EN : when defined, pending writes win arbitration over
//                           reads (round-robin within the write set first).
// -----------------------------------------------------------------------------
module ram_arbiter
  import cpu_types_pkg::*;
  import ram_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WORD_W = 32
) (
  input  logic          CLK,
  input  logic          nRST,
  ram_arbiter_if.slave  bus
);

  localparam int PTR_W = $clog2(NREQ);

  arb_state_t        state_q;
  logic [PTR_W-1:0]  owner_q;
  logic [PTR_W-1:0]  rr_ptr_q;
  logic [PTR_W-1:0]  rr_ptr_d;
  logic [NREQ-1:0]   grant_q;
  logic              is_write_q;
  logic              burst_q;

  logic [NREQ-1:0]   active;
  logic [NREQ-1:0]   win;
  logic              win_valid;
  logic [PTR_W-1:0]  win_idx;
  logic              owner_live;
  logic              drive;
  logic [WORD_W-1:0] cur_addr;

  logic              ram_ren;
  logic              ram_wen;
  logic [WORD_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_store;
  logic [NREQ-1:0]   wait_n;
  logic [NREQ-1:0]   err;
  logic [WORD_W-1:0] load;

  assign active = bus.req_ren | bus.req_wen;

`ifdef RAM_ARB_WRITE_PRIO_EN
  logic [NREQ-1:0] wr_gnt;
  logic [NREQ-1:0] all_gnt;
  logic            wr_valid;
  logic            all_valid;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_wr (
    .req_i   (bus.req_wen),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (wr_gnt),
    .valid_o (wr_valid)
  );

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_all (
    .req_i   (active),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (all_gnt),
    .valid_o (all_valid)
  );

  // Reads are only considered when no write is pending.
  assign win       = wr_valid ? wr_gnt : all_gnt;
  assign win_valid = all_valid;
`else
  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick_all (
    .req_i   (active),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (win),
    .valid_o (win_valid)
  );
`endif

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = PTR_W'(i);
    end
  end

  // Pointer moves just past the owner when its transaction ends.
  assign rr_ptr_d = (owner_q == PTR_W'(NREQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // Owner dropping both ren and wen aborts the transaction this very cycle.
  assign owner_live = active[owner_q];
  assign drive      = (state_q != IDLE) && owner_live;
  assign cur_addr   = bus.req_addr[owner_q];

  // NOTE: every output gets a default first so no path through the block
  // leaves a value unassigned, which would otherwise infer a latch.
  always_comb begin
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    wait_n    = '1;
    err       = '0;
    load      = '0;
    if (drive) begin
      ram_ren   = !is_write_q;
      ram_wen   = is_write_q;
      // The +4 wraps naturally in WORD_W bits.
      ram_addr  = (state_q == WORD1) ? cur_addr + WORD_W'(WORD_BYTES) : cur_addr;
      ram_store = bus.req_store[owner_q];
      if (bus.ramstate == ACCESS) begin
        wait_n = ~grant_q;
        load   = bus.ramload;
      end else if (bus.ramstate == ERROR) begin
        wait_n = ~grant_q;
        err    = grant_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      is_write_q <= 1'b0;
      burst_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            state_q    <= WORD0;
            owner_q    <= win_idx;
            grant_q    <= win;
            is_write_q <= |(win & bus.req_wen);
            burst_q    <= |(win & bus.req_burst);
          end
        end
        WORD0, WORD1: begin
          if (!owner_live) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end else if (bus.ramstate == ACCESS && state_q == WORD0 && burst_q) begin
            state_q <= WORD1;
          end else if (bus.ramstate == ACCESS || bus.ramstate == ERROR) begin
            // Completion, or an error that cancels any remaining word.
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.req_wait = wait_n;
  assign bus.req_err  = err;
  assign bus.req_load = load;
  assign bus.req_word = (state_q == WORD1);
  assign bus.grant    = grant_q;

endmodule : ram_arbiter
